// File: rtl/riscv_v_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_v_pipe_ctrl
//   Valid/ready control for a linear chain of NUM_STAGES pipeline stage
//   registers. It generates per-stage load enables and flushes, tracks a
//   valid bit per stage, and supports drain/halt/resume sequencing. It also
//   keeps retire and stall performance counters.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  upstream handshake into stage 0
//   out_valid/ready downstream handshake out of stage NUM_STAGES-1
//   stall_req       per-stage hazard hold (bit i holds stage i)
//   flush_req/idx   kill stages 0..flush_idx
//   drain_req       stop intake and empty the pipe; resume leaves HALTED
//   stage_en        load enable per stage register
//   stage_flush     flush per stage register
//   stage_valid     registered valid bit per stage
//   occupancy       popcount of stage_valid
//   drained         high while HALTED
//   retire_cnt      wrapping count of output transfers
//   stall_cnt       saturating count of cycles with a stalled valid stage
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal operation, intake open
// DRAIN  | intake closed, pipe keeps advancing until it is empty
// HALTED | pipe empty and idle, drained=1, waiting for resume
// ---------------------------------------------------------------------------
module riscv_v_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int OCC_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [IDX_W-1:0]      flush_idx,
  input  logic                  drain_req,
  input  logic                  resume,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  drained,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_STAGES-1:0] r_valid;
  logic [CNT_W-1:0]      r_retire_cnt;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [NUM_STAGES-1:0] w_ready;
  logic [NUM_STAGES-1:0] w_en;
  logic [NUM_STAGES-1:0] w_flush;
  logic [NUM_STAGES-1:0] w_load;
  logic [NUM_STAGES-1:0] w_valid_nxt;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_in_acc;
  logic                  w_xfer;

  // Backpressure ripples from the output end toward stage 0. The carry is a
  // local so the vector never depends on itself inside this block.
  always_comb begin : ready_chain
    logic w_carry;
    w_carry = out_ready;
    w_ready = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      w_carry    = ~stall_req[i] & (~r_valid[i] | w_carry);
      w_ready[i] = w_carry;
    end
  end

  // Flush index wider than the pipe naturally covers every stage.
  always_comb begin
    w_flush = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_flush[i] = flush_req & (IDX_W'(i) <= flush_idx);
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end

  assign in_ready = w_ready[0] & (r_state == S_RUN) & ~flush_req;
  assign w_in_acc = in_valid & in_ready;

  // Value each stage would load: stage 0 takes the accepted input, stage i
  // takes stage i-1 unless that stage is stalled (then a bubble).
  assign w_load = NUM_STAGES'({r_valid & ~stall_req, w_in_acc});

  // Enables and flushes are forced low while reset is held.
  assign w_en        = w_ready & {NUM_STAGES{~rst}};
  assign stage_en    = w_en;
  assign stage_flush = w_flush & {NUM_STAGES{~rst}};

  // Flush wins over both enable and hold.
  assign w_valid_nxt = ((r_valid & ~w_en) | (w_load & w_en)) & ~w_flush;

  assign out_valid = r_valid[NUM_STAGES-1] & ~stall_req[NUM_STAGES-1];
  assign w_xfer    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_valid      <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_valid <= w_valid_nxt;

      if (w_xfer) begin
        r_retire_cnt <= r_retire_cnt + 1'b1;
      end

      if ((|(stall_req & r_valid)) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      case (r_state)
        S_RUN: begin
          if (drain_req) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_occ == '0) begin
            r_state <= S_HALTED;
          end
        end
        S_HALTED: begin
          if (resume) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign stage_valid = r_valid;
  assign occupancy   = w_occ;
  assign drained     = (r_state == S_HALTED);
  assign retire_cnt  = r_retire_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_v_pipe_ctrl
//   Directed bench for riscv_v_pipe_ctrl (NUM_STAGES=4, CNT_W=4 so counter
//   wrap and saturation are reachable). A reference model carries op tags
//   through the stages; a compare process checks every output on each
//   falling edge, and directed phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_riscv_v_pipe_ctrl;

  localparam int NS    = 4;
  localparam int CW    = 4;
  localparam int IDX_W = 2;
  localparam int OCC_W = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [NS-1:0]     stall_req;
  logic              flush_req;
  logic [IDX_W-1:0]  flush_idx;
  logic              drain_req;
  logic              resume;
  logic [NS-1:0]     stage_en;
  logic [NS-1:0]     stage_flush;
  logic [NS-1:0]     stage_valid;
  logic [OCC_W-1:0]  occupancy;
  logic              drained;
  logic [CW-1:0]     retire_cnt;
  logic [CW-1:0]     stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  riscv_v_pipe_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .flush_idx  (flush_idx),
    .drain_req  (drain_req),
    .resume     (resume),
    .stage_en   (stage_en),
    .stage_flush(stage_flush),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .drained    (drained),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_tag[i] is the id of the op held in stage i (0 = empty).
  int m_tag [NS];
  int m_st   = 0;   // 0 run, 1 drain, 2 halted
  int m_ret  = 0;
  int m_stl  = 0;
  int next_id = 1;

  logic [NS-1:0] e_ready, e_en, e_flush, e_valid;
  logic          e_in_ready, e_out_valid;
  int            e_occ;

  always_comb begin
    logic carry;
    carry       = out_ready;
    e_ready     = '0;
    e_valid     = '0;
    e_flush     = '0;
    e_occ       = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      e_ready[i] = !stall_req[i] && (m_tag[i] == 0 || carry);
      carry      = e_ready[i];
    end
    for (int i = 0; i < NS; i++) begin
      e_valid[i] = (m_tag[i] != 0);
      if (m_tag[i] != 0) e_occ = e_occ + 1;
      e_flush[i] = flush_req && (i <= int'(flush_idx));
    end
    e_in_ready  = e_ready[0] && (m_st == 0) && !flush_req;
    e_out_valid = (m_tag[NS-1] != 0) && !stall_req[NS-1];
    e_en        = rst ? '0 : e_ready;
    if (rst) e_flush = '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) m_tag[i] <= 0;
      m_st  <= 0;
      m_ret <= 0;
      m_stl <= 0;
    end else begin
      if (e_flush[0])      m_tag[0] <= 0;
      else if (e_ready[0]) m_tag[0] <= (in_valid && e_in_ready) ? next_id : 0;
      for (int i = 1; i < NS; i++) begin
        if (e_flush[i])      m_tag[i] <= 0;
        else if (e_ready[i]) m_tag[i] <= stall_req[i-1] ? 0 : m_tag[i-1];
      end
      if (in_valid && e_in_ready) next_id <= next_id + 1;
      if (e_out_valid && out_ready) m_ret <= (m_ret + 1) % (CMAX + 1);
      if (((stall_req & e_valid) != '0) && m_stl < CMAX) m_stl <= m_stl + 1;
      case (m_st)
        0: if (drain_req) m_st <= 1;
        1: if (e_occ == 0) m_st <= 2;
        2: if (resume) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready",    in_ready,    e_in_ready);
    chk("out_valid",   out_valid,   e_out_valid);
    chk("stage_en",    stage_en,    e_en);
    chk("stage_flush", stage_flush, e_flush);
    chk("stage_valid", stage_valid, e_valid);
    chk("occupancy",   occupancy,   e_occ);
    chk("drained",     drained,     (m_st == 2));
    chk("retire_cnt",  retire_cnt,  m_ret);
    chk("stall_cnt",   stall_cnt,   m_stl);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stall_req = '0;
    flush_req = 1'b0; flush_idx = '0; drain_req = 1'b0; resume = 1'b0;

    // reset behaviour of combinational outputs
    tick();
    #1 chk("rst_in_ready", in_ready, 1);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_stage_valid", stage_valid, 0);
    flush_req = 1'b1; flush_idx = 2'd3;
    #1 chk("rst_stage_flush", stage_flush, 0);
    chk("rst_in_ready_flush", in_ready, 0);
    flush_req = 1'b0;

    // streaming latency and throughput
    tick();
    rst = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    #1 chk("lat_out_valid_early", out_valid, 0);
    tick();
    #1 chk("lat_out_valid", out_valid, 1);
    chk("lat_full", stage_valid, 4'b1111);
    repeat (10) tick();
    #1 chk("stream_retire", retire_cnt, 10);

    // stage 1 stalled for three cycles
    stall_req = 4'b0010;
    #1 chk("stall_in_ready", in_ready, 0);
    chk("stall_en", stage_en, 4'b1100);
    tick();
    #1 chk("stall_bubble", stage_valid, 4'b1011);
    repeat (2) tick();
    stall_req = '0;
    #1 chk("stall_cnt3", stall_cnt, 3);

    // flush of stages 0..1 on a full pipe
    repeat (4) tick();
    #1 chk("refill", stage_valid, 4'b1111);
    flush_req = 1'b1; flush_idx = 2'd1;
    #1 chk("flush_mask", stage_flush, 4'b0011);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush_req = 1'b0; in_valid = 1'b0;
    #1 chk("flush_after", stage_valid, 4'b1100);

    // downstream backpressure
    in_valid = 1'b1;
    repeat (4) tick();
    #1 chk("bp_full", stage_valid, 4'b1111);
    out_ready = 1'b0;
    #1 chk("bp_in_ready", in_ready, 0);
    chk("bp_en", stage_en, 0);
    repeat (2) tick();
    #1 chk("bp_hold", stage_valid, 4'b1111);
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) tick();
    #1 chk("bp_empty", stage_valid, 0);
    chk("bp_out_valid", out_valid, 0);

    // drain with three ops in flight
    in_valid = 1'b1;
    repeat (3) tick();
    #1 chk("drain_occ3", occupancy, 3);
    drain_req = 1'b1; in_valid = 1'b0;
    tick();
    drain_req = 1'b0;
    #1 chk("drain_in_ready", in_ready, 0);
    chk("drain_occ_still3", occupancy, 3);
    repeat (3) tick();
    #1 chk("drain_occ0", occupancy, 0);
    chk("drain_not_yet", drained, 0);
    tick();
    #1 chk("drain_halted", drained, 1);
    chk("halt_in_ready", in_ready, 0);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    #1 chk("halt_ignore_drain", drained, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1 chk("resume_in_ready", in_ready, 1);
    chk("resume_drained", drained, 0);

    // drain on an empty pipe passes through DRAIN for one cycle
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    #1 chk("empty_drain_step", drained, 0);
    tick();
    #1 chk("empty_drain_halt", drained, 1);
    resume = 1'b1;
    tick();
    tick();
    resume = 1'b0;
    #1 chk("resume_in_run_ignored", drained, 0);

    // stall counter saturation
    in_valid = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0; stall_req = 4'b1000;
    repeat (16) tick();
    #1 chk("stall_sat", stall_cnt, CMAX);
    stall_req = '0; out_ready = 1'b1;

    // asynchronous reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b1;
    repeat (9) tick();
    #1 chk("pre_rst_retire", retire_cnt, 5);
    chk("pre_rst_full", stage_valid, 4'b1111);
    #2 rst = 1'b1;
    #1 chk("async_rst_valid", stage_valid, 0);
    chk("async_rst_retire", retire_cnt, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_stall", stall_cnt, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    #1 chk("post_rst_retire", retire_cnt, 0);
    chk("post_rst_out_valid", out_valid, 0);

    // retire counter wraps modulo 2^CW
    in_valid = 1'b1;
    repeat (20) tick();
    #1 chk("retire_wrap0", retire_cnt, 0);
    tick();
    #1 chk("retire_wrap1", retire_cnt, 1);

    in_valid = 1'b0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
